// File: rtl/r22sdf_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | r22sdf_reorder: turns the bit-reversed R2^2SDF output into natural order  |
// | through a ping-pong RAM, emitting an indexed stream with frame markers.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module r22sdf_reorder #(
    parameter int data_resolution = 16,
    parameter int fft_length      = 64
) (
    input  logic                               sys_clk,
    input  logic                               sys_nrst,
    input  logic                               sys_en,
    input  logic                               din_vld,
    input  logic                               din_sop,
    input  logic [data_resolution-1:0]         din_r,
    input  logic [data_resolution-1:0]         din_i,
    output logic                               dout_vld,
    output logic                               dout_sop,
    output logic                               dout_eop,
    output logic [$clog2(fft_length)-1:0]      dout_idx,
    output logic [data_resolution-1:0]         dout_r,
    output logic [data_resolution-1:0]         dout_i,
    output logic                               err_sop
);

    localparam int                c_logn = $clog2(fft_length);
    localparam int                c_n    = fft_length;
    localparam logic [c_logn-1:0] c_last = c_logn'(c_n - 1);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic logic [c_logn-1:0] bitrev(input logic [c_logn-1:0] a);
        logic [c_logn-1:0] r;
        for (int b = 0; b < c_logn; b++) begin
            r[b] = a[c_logn-1-b];
        end
        return r;
    endfunction

    // Address MSB selects the bank; both banks share one array.
    logic [data_resolution-1:0] mem_r [2*c_n];
    logic [data_resolution-1:0] mem_i [2*c_n];

    logic [c_logn-1:0]          wr_cnt_q,   wr_cnt_d;
    logic                       wr_bank_q,  wr_bank_d;
    logic [1:0]                 full_q,     full_d;
    logic                       err_sop_q,  err_sop_d;
    rd_state_t                  rd_state_q, rd_state_d;
    logic [c_logn-1:0]          rd_cnt_q,   rd_cnt_d;
    logic                       rd_bank_q,  rd_bank_d;
    logic                       rvld_q,     rvld_d;
    logic [c_logn-1:0]          ridx_q,     ridx_d;
    logic [data_resolution-1:0] ram_r_q,    ram_r_d;
    logic [data_resolution-1:0] ram_i_q,    ram_i_d;
    logic                       dout_vld_q, dout_vld_d;
    logic                       dout_sop_q, dout_sop_d;
    logic                       dout_eop_q, dout_eop_d;
    logic [c_logn-1:0]          dout_idx_q, dout_idx_d;
    logic [data_resolution-1:0] dout_r_q,   dout_r_d;
    logic [data_resolution-1:0] dout_i_q,   dout_i_d;

    logic                       accept;
    logic                       frame_done;
    logic [c_logn-1:0]          wr_ptr;
    logic [c_logn:0]            wr_addr;
    logic                       rd_go;
    logic                       rd_last;
    logic [c_logn:0]            rd_addr;

    always_comb begin
        accept     = sys_en & din_vld;
        // A sop always restarts the frame at position 0, dropping any partial frame.
        wr_ptr     = (accept & din_sop) ? '0 : wr_cnt_q;
        wr_addr    = {wr_bank_q, bitrev(wr_ptr)};
        frame_done = accept & (wr_ptr == c_last);

        wr_cnt_d   = wr_cnt_q;
        if (frame_done) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_ptr + 1'b1;
        end
        wr_bank_d  = wr_bank_q ^ frame_done;
        err_sop_d  = sys_en ? (accept & din_sop & (wr_cnt_q != '0)) : err_sop_q;

        // An idle reader starts on the same cycle it sees its bank full.
        rd_go      = sys_en & ((rd_state_q == RD_READ) | full_q[rd_bank_q]);
        rd_last    = rd_go & (rd_cnt_q == c_last);
        rd_addr    = {rd_bank_q, rd_cnt_q};

        full_d     = full_q;
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
        end

        rd_cnt_d   = rd_cnt_q;
        rd_state_d = rd_state_q;
        if (rd_go) begin
            if (rd_last) begin
                rd_cnt_d   = '0;
                rd_state_d = full_q[rd_bank_q ^ 1'b1] ? RD_READ : RD_IDLE;
            end else begin
                rd_cnt_d   = rd_cnt_q + 1'b1;
                rd_state_d = RD_READ;
            end
        end
        rd_bank_d  = rd_bank_q ^ rd_last;

        rvld_d     = sys_en ? rd_go : rvld_q;
        ridx_d     = rd_go ? rd_cnt_q : ridx_q;
        ram_r_d    = rd_go ? mem_r[rd_addr] : ram_r_q;
        ram_i_d    = rd_go ? mem_i[rd_addr] : ram_i_q;

        dout_vld_d = dout_vld_q;
        dout_sop_d = dout_sop_q;
        dout_eop_d = dout_eop_q;
        dout_idx_d = dout_idx_q;
        dout_r_d   = dout_r_q;
        dout_i_d   = dout_i_q;
        if (sys_en) begin
            dout_vld_d = rvld_q;
            dout_sop_d = rvld_q & (ridx_q == '0);
            dout_eop_d = rvld_q & (ridx_q == c_last);
            dout_idx_d = ridx_q;
            dout_r_d   = ram_r_q;
            dout_i_d   = ram_i_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem_r[wr_addr] <= din_r;
            mem_i[wr_addr] <= din_i;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            err_sop_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rvld_q     <= 1'b0;
            ridx_q     <= '0;
            ram_r_q    <= '0;
            ram_i_q    <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_idx_q <= '0;
            dout_r_q   <= '0;
            dout_i_q   <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            err_sop_q  <= err_sop_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rvld_q     <= rvld_d;
            ridx_q     <= ridx_d;
            ram_r_q    <= ram_r_d;
            ram_i_q    <= ram_i_d;
            dout_vld_q <= dout_vld_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_idx_q <= dout_idx_d;
            dout_r_q   <= dout_r_d;
            dout_i_q   <= dout_i_d;
        end
    end

    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout_idx = dout_idx_q;
    assign dout_r   = dout_r_q;
    assign dout_i   = dout_i_q;
    assign err_sop  = err_sop_q;

endmodule
`default_nettype wire

// File: tb/tb_r22sdf_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_r22sdf_reorder: scoreboard bench for the natural-order reorder buffer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_r22sdf_reorder;

    localparam int DW   = 16;
    localparam int N    = 16;
    localparam int LOGN = 4;

    logic            sys_clk  = 1'b0;
    logic            sys_nrst = 1'b0;
    logic            sys_en   = 1'b1;
    logic            din_vld  = 1'b0;
    logic            din_sop  = 1'b0;
    logic [DW-1:0]   din_r    = '0;
    logic [DW-1:0]   din_i    = '0;
    logic            dout_vld;
    logic            dout_sop;
    logic            dout_eop;
    logic [LOGN-1:0] dout_idx;
    logic [DW-1:0]   dout_r;
    logic [DW-1:0]   dout_i;
    logic            err_sop;

    r22sdf_reorder #(.data_resolution(DW), .fft_length(N)) dut (
        .sys_clk (sys_clk),
        .sys_nrst(sys_nrst),
        .sys_en  (sys_en),
        .din_vld (din_vld),
        .din_sop (din_sop),
        .din_r   (din_r),
        .din_i   (din_i),
        .dout_vld(dout_vld),
        .dout_sop(dout_sop),
        .dout_eop(dout_eop),
        .dout_idx(dout_idx),
        .dout_r  (dout_r),
        .dout_i  (dout_i),
        .err_sop (err_sop)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0]   r;
        logic [DW-1:0]   i;
        logic [LOGN-1:0] idx;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    int            err_seen = 0;
    int            vld_seen = 0;
    int            sop_edge = -1;
    int            b2b_seen = 0;
    int            last_acc_edge = 0;
    int            overrun = 0;
    bit            chk_b2b = 1'b0;
    bit            prev_vld = 1'b0;
    bit            mon_en;
    exp_t          mon_e;

    // Reference model: arrival position k carries bin bitrev(k).
    logic [DW-1:0] m_r [N];
    logic [DW-1:0] m_i [N];
    int            m_pos = 0;

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < LOGN; b++) r = (r << 1) | ((k >> b) & 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_accept(input logic sop, input logic [DW-1:0] r, input logic [DW-1:0] im);
        exp_t e;
        if (sop) m_pos = 0;
        m_r[m_pos] = r;
        m_i[m_pos] = im;
        m_pos++;
        if (m_pos == N) begin
            for (int j = 0; j < N; j++) begin
                e.r   = m_r[brev(j)];
                e.i   = m_i[brev(j)];
                e.idx = LOGN'(j);
                exp_q.push_back(e);
            end
            m_pos = 0;
        end
    endtask

    task automatic cyc(input logic vld, input logic sop, input logic [DW-1:0] r, input logic [DW-1:0] im);
        @(negedge sys_clk);
        din_vld = vld;
        din_sop = sop & vld;
        din_r   = r;
        din_i   = im;
        last_acc_edge = edge_cnt + 1;
        if (sys_en && sys_nrst && vld) model_accept(sop, r, im);
    endtask

    task automatic send_frame(input int roff, input int gap, input bit rnd);
        logic [DW-1:0] r, im;
        for (int k = 0; k < N; k++) begin
            while ($urandom_range(0, 99) < gap) cyc(1'b0, 1'b0, '0, '0);
            r  = rnd ? DW'($urandom) : DW'(brev(k) + roff);
            im = rnd ? DW'($urandom) : DW'(-brev(k));
            cyc(1'b1, k == 0, r, im);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1'b0, 1'b0, '0, '0);
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) cyc(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_idx(input int idx, input string name);
        int n = 0;
        do begin
            cyc(1'b0, 1'b0, '0, '0);
            n++;
        end while (!(dout_vld && dout_idx == LOGN'(idx)) && n < 100);
        chk(name, {63'd0, dout_vld && dout_idx == LOGN'(idx)}, 64'd1);
    endtask

    // Monitor: a new output exists only after an edge where sys_en was high.
    always @(posedge sys_clk) begin
        mon_en = sys_en && sys_nrst;
        edge_cnt++;
        if (sys_nrst && sys_en && din_vld && dut.full_q[dut.wr_bank_q]) overrun++;
        #1;
        if (mon_en) begin
            if (err_sop) err_seen++;
            if (dout_vld) begin
                vld_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got idx %0d r %0h, expected no output", dout_idx, dout_r);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dout", {26'd0, dout_sop, dout_eop, dout_idx, dout_r, dout_i},
                        {26'd0, mon_e.idx == '0, mon_e.idx == LOGN'(N - 1), mon_e.idx, mon_e.r, mon_e.i});
                end
                if (dout_idx != '0) chk("burst_contiguous", {63'd0, prev_vld}, 64'd1);
                if (dout_sop) sop_edge = edge_cnt;
                if (chk_b2b) begin
                    if (dout_sop && b2b_seen > 0) chk("frame_gap", {63'd0, prev_vld}, 64'd1);
                    b2b_seen++;
                end
            end
            prev_vld = dout_vld;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, e0, v0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("reset_outputs", {24'd0, dout_vld, dout_sop, dout_eop, dout_idx, dout_r, dout_i, err_sop}, 64'd0);
        sys_nrst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, '0, '0);

        // Single frame, natural order and latency.
        send_frame(0, 0, 1'b0);
        lat = last_acc_edge;
        drain(100);
        chk("first_out_latency", 64'(sop_edge - lat), 64'd2);

        // Three back-to-back frames.
        chk_b2b  = 1'b1;
        b2b_seen = 0;
        send_frame(0, 0, 1'b0);
        send_frame(100, 0, 1'b0);
        send_frame(200, 0, 1'b0);
        drain(200);
        chk_b2b = 1'b0;
        chk("b2b_output_count", 64'(b2b_seen), 64'd48);

        // Random input gaps, fixed then random data.
        send_frame(0, 50, 1'b0);
        drain(200);
        send_frame(0, 50, 1'b1);
        send_frame(0, 30, 1'b1);
        drain(300);

        // Clock-enable freeze at output index 7.
        send_frame(0, 0, 1'b0);
        wait_idx(7, "reach_idx7");
        sys_en = 1'b0;
        repeat (5) begin
            @(negedge sys_clk);
            chk("hold_idx7", {27'd0, dout_vld, dout_idx, dout_r, dout_i}, {27'd0, 1'b1, 4'd7, 16'd7, 16'hFFF9});
        end
        sys_en = 1'b1;
        drain(100);

        // Unexpected sop after 5 samples drops the partial frame.
        e0 = err_seen;
        for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, DW'(brev(k) + 50), DW'(k));
        send_frame(300, 0, 1'b0);
        drain(100);
        chk("err_sop_pulses", 64'(err_seen - e0), 64'd1);

        // Asynchronous reset mid-read.
        send_frame(0, 0, 1'b1);
        wait_idx(9, "reach_idx9");
        sys_nrst = 1'b0;
        exp_q.delete();
        m_pos = 0;
        #1;
        chk("async_reset_clears", {24'd0, dout_vld, dout_sop, dout_eop, dout_idx, dout_r, dout_i, err_sop}, 64'd0);
        @(negedge sys_clk);
        sys_nrst = 1'b1;
        v0 = vld_seen;
        repeat (30) cyc(1'b0, 1'b0, '0, '0);
        chk("no_output_after_reset", 64'(vld_seen - v0), 64'd0);
        send_frame(500, 0, 1'b0);
        drain(100);

        chk("no_overrun", 64'(overrun), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r22sdf_reorder.md
Name: r22sdf_reorder

Overview:
- Output reorder buffer at the tail of the R2²SDF pipeline, after the last stage module.
- The stage chain emits each frame in bit-reversed index order. This block writes every sample to the bit-reversed address of its arrival position in a ping-pong RAM, then reads the bank out linearly.
- Result: a natural-order stream with frame markers.
- One bank fills while the other drains, so continuous back-to-back frames are supported.

Parameters:
- data_resolution, 16, bit width of each real/imag sample.
- fft_length, 64, points per frame; power of 2, minimum 4 (log2 of this = LOGN).

Ports:
- sys_clk  input  1  clock.
- sys_nrst  input  1  asynchronous active-low reset.
- sys_en  input  1  global clock enable; when low, every register holds.
- din_vld  input  1  input sample valid.
- din_sop  input  1  marks sample 0 of a frame; qualified by din_vld.
- din_r  input  data_resolution  real part, bit-reversed order.
- din_i  input  data_resolution  imaginary part.
- dout_vld  output  1  output sample valid.
- dout_sop  output  1  high with output index 0.
- dout_eop  output  1  high with output index fft_length-1.
- dout_idx  output  LOGN  natural-order bin index of dout.
- dout_r  output  data_resolution  real part, natural order.
- dout_i  output  data_resolution  imaginary part.
- err_sop  output  1  one-cycle pulse when an unexpected din_sop discards a partial frame.

Behaviour:
- Reset:
  - All outputs 0.
  - wr_cnt=0, wr_bank=0, reader IDLE, no bank marked full.
  - RAM contents are don't-care.
- Accept condition: sys_en & din_vld.
- Write side:
  - An accepted sample is written to bank wr_bank at address bitrev(wr_cnt) over LOGN bits; wr_cnt then increments.
  - din_sop accepted while wr_cnt≠0: the partial frame is dropped, the sample is written at bitrev(0), wr_cnt←1, and err_sop pulses on the next edge.
  - din_sop with wr_cnt=0 is normal.
  - Before any sop, samples are still accepted; the count starts at 0 after reset.
- Frame complete (accept with wr_cnt=N-1):
  - wr_cnt←0 and wr_bank toggles.
  - Completed bank is flagged full and a read request is raised.
- Reader FSM: IDLE → READ on a read request. READ: rd_cnt 0..N-1, one address per sys_en cycle; after rd_cnt=N-1 the FSM returns to IDLE, or stays in READ with rd_cnt←0 on the other bank if that bank's request is already pending.
- Read pipeline and latency:
  - RAM read is synchronous; the output register adds one stage.
  - With sys_en continuously high, dout for index 0 is valid on the 2nd rising edge after the edge that accepts sample N-1.
  - dout_idx = registered rd_cnt. sop/eop are aligned with dout_vld.
- Overrun: cannot occur. The reader drains 1 sample/cycle while the writer fills at most 1 sample/cycle, so a bank finishes draining no later than the other bank fills. An assertion in verification checks that a bank is never written while flagged full and not yet drained.
- sys_en low: the write counter, reader, RAM-read pipeline and output registers all freeze. Outputs hold their values, including dout_vld.
- Gaps in din_vld: the write side pauses. The reader continues on any full bank.
- Reset asserted mid-frame or mid-read: immediate clear to the reset state. The partial frame and the undrained bank are lost, and no output appears until a new complete frame is written.
- Width: data passes unmodified; no scaling or rounding.

Test Plan:
- N=16, one frame, din_r=bitrev4(k), din_i=-bitrev4(k), k=0..15 (din_r sequence 0,8,4,12,2,…):
  - dout_r=0,1,…,15 and dout_i=0,-1,…,-15.
  - dout_idx=0..15; sop on the first output, eop on the last.
  - First dout_vld on the 2nd edge after the last input.
- Three back-to-back frames (offsets 0, 100, 200 on real), din_vld constantly high:
  - 48 contiguous valid outputs, each frame in natural order, no gaps between frames.
- Random din_vld gaps, ~50% duty:
  - Output content is identical to scenario 1.
  - Each output burst is 16 contiguous cycles.
- sys_en low for 5 cycles mid-read at output index 7:
  - dout holds index 7 for those cycles.
  - Output resumes at 8 with no loss or duplication.
- din_sop asserted after 5 samples, then a full 16-sample frame:
  - err_sop pulses once.
  - Only the full frame appears at the output, in correct order.
- sys_nrst pulsed low at output index 9:
  - All outputs 0 immediately.
  - No further dout_vld until a new complete frame is written.
